// File: rtl/byte_serial_subtractor.sv
// byte_serial_subtractor
//   Multi-cycle WIDTH-bit subtractor, D = A - B - iBorrowIn, computed one
//   8-bit slice per cycle, LSB slice first. Each slice adds the minuend byte
//   to the inverted subtrahend byte plus a carry; carry = ~borrow, so the
//   carry register is seeded with ~iBorrowIn and oBorrow is ~(final carry).
//
//   Optional feature macro: SUB_OVERFLOW_FLAG_EN
//     defined   -> oOverflow is the signed-overflow flag of the subtraction
//     undefined -> oOverflow is tied to 0 (port kept for a fixed interface)
//
// Ports
//   iClk, iRstN      clock (rising edge), asynchronous active-low reset
//   iValid / oReady  operand handshake (oReady high only in IDLE)
//   iA, iB           minuend, subtrahend
//   iBorrowIn        borrow into the LSB slice
//   oValid / iReady  result handshake (oValid high only in DONE)
//   oDiff            A - B - iBorrowIn modulo 2^WIDTH
//   oBorrow          borrow out of the MSB slice
//   oOverflow        signed overflow flag (see macro above)
//
// WIDTH must be a multiple of 8 and at least 8.

module byte_serial_subtractor #(
   parameter int WIDTH = 32
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic             iValid,
   output logic             oReady,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iBorrowIn,
   output logic             oValid,
   input  logic             iReady,
   output logic [WIDTH-1:0] oDiff,
   output logic             oBorrow,
   output logic             oOverflow
);

   localparam int SLICES = WIDTH / 8;
   localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [CW-1:0] LAST_SLICE = CW'(SLICES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] a_q, b_q, diff_q;
   logic             borrow_q;

   logic [7:0]       a8, b8;
   logic [8:0]       sum;
   logic             last;
   int               base;

   // Current slice datapath
   always_comb begin
      base = int'(cnt) * 8;
      a8   = a_q[base +: 8];
      b8   = b_q[base +: 8];
      sum  = {1'b0, a8} + {1'b0, ~b8} + {8'd0, carry};
      last = (cnt == LAST_SLICE);
   end

   // State register
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (iValid) state_nxt = RUN;
         RUN:     if (last)   state_nxt = DONE;
         DONE:    if (iReady) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign oReady = (state == IDLE);
   assign oValid = (state == DONE);

   // Datapath registers
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         borrow_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (iValid) begin
               a_q   <= iA;
               b_q   <= iB;
               carry <= ~iBorrowIn;
               cnt   <= '0;
            end
            RUN: begin
               diff_q[base +: 8] <= sum[7:0];
               carry             <= sum[8];
               if (last) begin
                  borrow_q <= ~sum[8];
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign oDiff   = diff_q;
   assign oBorrow = borrow_q;

`ifdef SUB_OVERFLOW_FLAG_EN
   // Signed overflow: operands of opposite sign and result sign differs
   // from the minuend. sum[7] on the last slice is the result MSB.
   logic ovf_q;
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) ovf_q <= 1'b0;
      else if (state == RUN && last)
         ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[7] != a_q[WIDTH-1]);
   end
   assign oOverflow = ovf_q;
`else
   assign oOverflow = 1'b0;
`endif

endmodule

// File: tb/tb_byte_serial_subtractor.sv
// Directed bench for byte_serial_subtractor (WIDTH=32). A reference model
// computes the full-width subtraction arithmetically; a compare process
// checks every cycle oValid is high, and directed tests add literal checks.

module tb_byte_serial_subtractor;

   localparam int W = 32;

   logic         iClk = 1'b0;
   logic         iRstN = 1'b0;
   logic         iValid = 1'b0;
   logic         oReady;
   logic [W-1:0] iA = '0;
   logic [W-1:0] iB = '0;
   logic         iBorrowIn = 1'b0;
   logic         oValid;
   logic         iReady = 1'b1;
   logic [W-1:0] oDiff;
   logic         oBorrow;
   logic         oOverflow;

   byte_serial_subtractor #(.WIDTH(W)) dut (
      .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
      .iA(iA), .iB(iB), .iBorrowIn(iBorrowIn), .oValid(oValid),
      .iReady(iReady), .oDiff(oDiff), .oBorrow(oBorrow), .oOverflow(oOverflow)
   );

   always #5 iClk = ~iClk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: operands of the operation in flight
   logic [W-1:0] m_a = '0, m_b = '0;
   logic         m_bin = 1'b0;
   bit           m_valid = 1'b0;

   function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bin);
      return {1'b0, a} - {1'b0, b} - (W+1)'(bin);
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic bin);
`ifdef SUB_OVERFLOW_FLAG_EN
      logic [W:0] r;
      r = ref_sub(a, b, bin);
      return (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
`else
      return 1'b0;
`endif
   endfunction

   localparam logic OVF_ON =
`ifdef SUB_OVERFLOW_FLAG_EN
      1'b1;
`else
      1'b0;
`endif

   // Compare process: result must match the model whenever oValid is high
   always @(negedge iClk) begin
      if (iRstN && oValid) begin
         if (!m_valid) chk("spurious_valid", 64'(oValid), 64'd0);
         else begin
            logic [W:0] r;
            r = ref_sub(m_a, m_b, m_bin);
            chk("cmp_diff",   64'(oDiff),     64'(r[W-1:0]));
            chk("cmp_borrow", 64'(oBorrow),   64'(r[W]));
            chk("cmp_ovf",    64'(oOverflow), 64'(ref_ovf(m_a, m_b, m_bin)));
            chk("cmp_ready",  64'(oReady),    64'd0);
         end
      end
   end

   // Issue one operation; returns at the negedge where oValid is first seen
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit hold, output int lat);
      int n = 0;
      while (!oReady && n < 50) begin @(negedge iClk); n++; end
      if (!oReady) chk("ready_timeout", 64'(oReady), 64'd1);
      iA = a; iB = b; iBorrowIn = bin; iValid = 1'b1; iReady = !hold;
      m_a = a; m_b = b; m_bin = bin; m_valid = 1'b1;
      @(negedge iClk);
      iValid = 1'b0;
      lat = 0;
      while (!oValid && lat < 20) begin @(negedge iClk); lat++; end
      if (!oValid) chk("valid_timeout", 64'(oValid), 64'd1);
   endtask

   task automatic finish_hs(input string name);
      @(negedge iClk);
      chk({name, "_valid_drop"}, 64'(oValid), 64'd0);
      chk({name, "_ready_back"}, 64'(oReady), 64'd1);
   endtask

   task automatic op_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input logic [W-1:0] ed, input logic eb);
      int lat;
      do_op(a, b, bin, 1'b0, lat);
      chk({name, "_lat"},    64'(lat),     64'd4);
      chk({name, "_diff"},   64'(oDiff),   64'(ed));
      chk({name, "_borrow"}, 64'(oBorrow), 64'(eb));
      finish_hs(name);
   endtask

   initial begin
      int lat;
      // Reset state (reset asserted from time 0)
      #1;
      chk("rst_valid",  64'(oValid),    64'd0);
      chk("rst_ready",  64'(oReady),    64'd1);
      chk("rst_diff",   64'(oDiff),     64'd0);
      chk("rst_borrow", 64'(oBorrow),   64'd0);
      chk("rst_ovf",    64'(oOverflow), 64'd0);
      repeat (2) @(negedge iClk);
      iRstN = 1'b1;
      @(negedge iClk);

      // 1. basic
      op_lit("t1", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0);
      // 2. underflow and borrow-in
      op_lit("t2a", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1);
      op_lit("t2b", 32'h0000_0005, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 1'b1);
      // 3. inter-slice borrow chain
      op_lit("t3a", 32'h1000_0000, 32'h0000_0001, 1'b0, 32'h0FFF_FFFF, 1'b0);
      op_lit("t3b", 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0);

      // 4. backpressure
      do_op(32'h0000_1234, 32'h0000_0234, 1'b0, 1'b1, lat);
      chk("t4_lat", 64'(lat), 64'd4);
      for (int i = 0; i < 10; i++) begin
         iValid = 1'b1; iA = $urandom; iB = $urandom; iBorrowIn = 1'($urandom);
         @(negedge iClk);
         chk("t4_hold_valid",  64'(oValid),  64'd1);
         chk("t4_hold_ready",  64'(oReady),  64'd0);
         chk("t4_hold_diff",   64'(oDiff),   64'h1000);
         chk("t4_hold_borrow", 64'(oBorrow), 64'd0);
      end
      iValid = 1'b0; iReady = 1'b1;
      finish_hs("t4");
      op_lit("t4_next", 32'h0000_0010, 32'h0000_0001, 1'b1, 32'h0000_000E, 1'b0);

      // 5. reset mid-RUN, after slice 1 is written
      iA = 32'hFFFF_FFFF; iB = 32'h0; iBorrowIn = 1'b0; iValid = 1'b1;
      m_a = iA; m_b = iB; m_bin = 1'b0; m_valid = 1'b1;
      @(negedge iClk); iValid = 1'b0;
      @(negedge iClk);
      @(negedge iClk);
      chk("t5_partial", 64'(oDiff[15:0]), 64'hFFFF);
      chk("t5_running", 64'(oReady), 64'd0);
      #2 iRstN = 1'b0; m_valid = 1'b0;
      #1;
      chk("t5_rst_valid",  64'(oValid),  64'd0);
      chk("t5_rst_diff",   64'(oDiff),   64'd0);
      chk("t5_rst_borrow", 64'(oBorrow), 64'd0);
      @(negedge iClk); iRstN = 1'b1;
      @(negedge iClk);
      chk("t5_ready", 64'(oReady), 64'd1);
      chk("t5_no_valid", 64'(oValid), 64'd0);
      op_lit("t5_after", 32'h1234_5678, 32'h0234_5670, 1'b0, 32'h1000_0008, 1'b0);

      // 6. signed overflow
      do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, lat);
      chk("t6a_diff",   64'(oDiff),     64'h7FFF_FFFF);
      chk("t6a_borrow", 64'(oBorrow),   64'd0);
      chk("t6a_ovf",    64'(oOverflow), 64'(OVF_ON));
      finish_hs("t6a");
      do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
      chk("t6b_diff",   64'(oDiff),     64'h8000_0000);
      chk("t6b_borrow", 64'(oBorrow),   64'd1);
      chk("t6b_ovf",    64'(oOverflow), 64'(OVF_ON));
      finish_hs("t6b");
      // no overflow: same-sign operands
      op_lit("t6c", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0001, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
